// File: rtl/lig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lig_pkg
// Brief    : Shared state and mode encodings for the LED pattern sequencer.
// Revision : 1.0
// ============================================================================
package lig_pkg;

    typedef enum logic [3:0] {
        S_ON          = 4'd0,
        S_OFF         = 4'd1,
        S_WALK_U      = 4'd2,
        S_WALK_D      = 4'd3,
        S_ALT         = 4'd4,
        S_END         = 4'd5,
        S_HOLD_BOUNCE = 4'd6,
        S_HOLD_ALT    = 4'd7,
        S_HOLD_ON     = 4'd8
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_ALT    = 2'b10;
    localparam logic [1:0] MODE_ON     = 2'b11;

    // Hold state that a non-auto mode selects.
    function automatic state_t hold_state(input logic [1:0] m);
        case (m)
            MODE_BOUNCE: return S_HOLD_BOUNCE;
            MODE_ALT:    return S_HOLD_ALT;
            default:     return S_HOLD_ON;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lig_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : lig_tick_gen
// Brief    : Step-rate divider; restarts its count whenever the rate changes.
// Revision : 1.0
// ============================================================================
module lig_tick_gen #(
    parameter int SLOW_DIV = 50000,
    parameter int FAST_DIV = 5000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic fast_i,
    output logic tick_o
);

    localparam int c_max_div = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int c_cnt_w   = $clog2(c_max_div);
    localparam logic [c_cnt_w-1:0] c_slow_last = c_cnt_w'(SLOW_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_fast_last = c_cnt_w'(FAST_DIV - 1);

    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;
    logic               fast_prev_q;
    logic               w_changed;
    logic               w_last;

    // A rate switch seen while paused is acted on at the first enabled cycle.
    always_comb begin
        w_changed = (fast_i != fast_prev_q);
        w_last    = (count_q == (fast_i ? c_fast_last : c_slow_last));
        tick_o    = en_i & ~w_changed & w_last;
        count_d   = count_q;
        if (en_i) begin
            if (w_changed || w_last) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q     <= '0;
            fast_prev_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (en_i) begin
                fast_prev_q <= fast_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lig_seq.sv
`default_nettype none
// ============================================================================
// Module   : lig_seq
// Brief    : Parametrised LED show sequencer with hold modes and rate control.
// Revision : 1.0
// ============================================================================
module lig_seq
    import lig_pkg::*;
#(
    parameter int N        = 8,
    parameter int SLOW_DIV = 50000,
    parameter int FAST_DIV = 5000,
    parameter int ALT_REPS = 2
) (
    input  logic         clk100khz,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic         fast_force,
    output logic [N-1:0] light,
    output logic         step,
    output logic         seq_done,
    output logic         fast
);

    localparam int c_idx_w = $clog2(N);
    localparam int c_alt_w = $clog2(2 * ALT_REPS);

    function automatic logic [N-1:0] f_alt_pat();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) begin
            p[i] = ((i % 2) == 0);
        end
        return p;
    endfunction

    localparam logic [N-1:0]       c_ones     = {N{1'b1}};
    localparam logic [N-1:0]       c_one      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]       c_alt_pat  = f_alt_pat();
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N - 1);
    localparam logic [c_idx_w-1:0] c_idx_pen  = c_idx_w'(N - 2);
    localparam logic [c_alt_w-1:0] c_alt_last = c_alt_w'(2 * ALT_REPS - 1);

    state_t             state_q;
    logic [N-1:0]       light_q;
    logic               step_q;
    logic               seq_done_q;
    logic               rate_fast_q;
    logic [c_idx_w-1:0] idx_q;
    logic               dir_up_q;
    logic [c_alt_w-1:0] alt_cnt_q;
    logic               w_fast;
    logic               w_tick;

    assign w_fast = rate_fast_q | fast_force;

    lig_tick_gen #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV)
    ) u_tick_gen (
        .clk_i  (clk100khz),
        .rst_i  (rst),
        .en_i   (en),
        .fast_i (w_fast),
        .tick_o (w_tick)
    );

    // state_q names the action the next tick performs; light is loaded on that tick.
    always_ff @(posedge clk100khz or posedge rst) begin
        if (rst) begin
            state_q     <= S_ON;
            light_q     <= '0;
            step_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            rate_fast_q <= 1'b0;
            idx_q       <= '0;
            dir_up_q    <= 1'b1;
            alt_cnt_q   <= '0;
        end else begin
            step_q     <= w_tick;
            seq_done_q <= 1'b0;
            if (w_tick) begin
                if (mode != MODE_AUTO) begin
                    if (state_q != hold_state(mode)) begin
                        state_q  <= hold_state(mode);
                        idx_q    <= c_idx_w'(1);
                        dir_up_q <= 1'b1;
                        case (mode)
                            MODE_BOUNCE: light_q <= c_one;
                            MODE_ALT:    light_q <= c_alt_pat;
                            default:     light_q <= c_ones;
                        endcase
                    end else begin
                        case (state_q)
                            S_HOLD_BOUNCE: begin
                                light_q <= c_one << idx_q;
                                if (dir_up_q) begin
                                    if (idx_q == c_idx_last) begin
                                        dir_up_q <= 1'b0;
                                        idx_q    <= idx_q - 1'b1;
                                    end else begin
                                        idx_q <= idx_q + 1'b1;
                                    end
                                end else begin
                                    if (idx_q == '0) begin
                                        dir_up_q <= 1'b1;
                                        idx_q    <= idx_q + 1'b1;
                                    end else begin
                                        idx_q <= idx_q - 1'b1;
                                    end
                                end
                            end
                            S_HOLD_ALT: light_q <= ~light_q;
                            default:    light_q <= c_ones;
                        endcase
                    end
                end else begin
                    case (state_q)
                        S_OFF: begin
                            light_q <= '0;
                            idx_q   <= '0;
                            state_q <= S_WALK_U;
                        end
                        S_WALK_U: begin
                            light_q <= c_one << idx_q;
                            if (idx_q == c_idx_last) begin
                                idx_q   <= c_idx_pen;
                                state_q <= S_WALK_D;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                        S_WALK_D: begin
                            light_q <= c_one << idx_q;
                            if (idx_q == '0) begin
                                alt_cnt_q <= '0;
                                state_q   <= S_ALT;
                            end else begin
                                idx_q <= idx_q - 1'b1;
                            end
                        end
                        S_ALT: begin
                            light_q <= (alt_cnt_q == '0) ? c_alt_pat : ~light_q;
                            if (alt_cnt_q == c_alt_last) begin
                                state_q <= S_END;
                            end else begin
                                alt_cnt_q <= alt_cnt_q + 1'b1;
                            end
                        end
                        S_END: begin
                            light_q     <= '0;
                            seq_done_q  <= 1'b1;
                            rate_fast_q <= ~rate_fast_q;
                            state_q     <= S_ON;
                        end
                        default: begin
                            // S_ON, or leaving any hold state back into the show.
                            light_q <= c_ones;
                            state_q <= S_OFF;
                        end
                    endcase
                end
            end
        end
    end

    assign light    = light_q;
    assign step     = step_q;
    assign seq_done = seq_done_q;
    assign fast     = w_fast;

endmodule
`default_nettype wire

// File: tb/tb_lig_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lig_seq
// Brief    : Self-checking bench for lig_seq against a pattern-list model.
// Revision : 1.0
// ============================================================================
module tb_lig_seq;

    localparam int N    = 8;
    localparam int SLOW = 4;
    localparam int FAST = 2;
    localparam int REPS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       fast_force = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] light;
    logic       step;
    logic       seq_done;
    logic       fast;

    always #5 clk = ~clk;

    lig_seq #(
        .N        (N),
        .SLOW_DIV (SLOW),
        .FAST_DIV (FAST),
        .ALT_REPS (REPS)
    ) dut (
        .clk100khz  (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .fast_force (fast_force),
        .light      (light),
        .step       (step),
        .seq_done   (seq_done),
        .fast       (fast)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] show_q[$];
    logic [7:0] bounce_q[$];
    logic [7:0] alt_q[$];

    int         m_cnt;
    logic       m_prev;
    logic       m_rate;
    bit         m_in_show;
    int         m_pos;
    int         m_hold;
    int         m_hpos;
    logic [7:0] m_light;
    logic       m_step;
    logic       m_done;

    task automatic model_reset();
        m_cnt     = 0;
        m_prev    = 1'b0;
        m_rate    = 1'b0;
        m_in_show = 1'b1;
        m_pos     = 0;
        m_hold    = 0;
        m_hpos    = 0;
        m_light   = 8'h00;
        m_step    = 1'b0;
        m_done    = 1'b0;
    endtask

    // One clock edge of the model, using the inputs present just before the edge.
    task automatic model_step();
        bit   tick;
        logic fe;
        int   div;
        if (rst) begin
            model_reset();
            return;
        end
        fe   = m_rate | fast_force;
        div  = fe ? FAST : SLOW;
        tick = 1'b0;
        if (en) begin
            if (fe != m_prev) m_cnt = 0;
            else if (m_cnt == div - 1) begin
                tick  = 1'b1;
                m_cnt = 0;
            end else m_cnt++;
            m_prev = fe;
        end
        m_step = tick;
        m_done = 1'b0;
        if (tick) begin
            if (mode == 2'b00) begin
                if (!m_in_show) begin
                    m_in_show = 1'b1;
                    m_hold    = 0;
                    m_pos     = 0;
                end
                m_light = show_q[m_pos];
                if (m_pos == show_q.size() - 1) begin
                    m_done = 1'b1;
                    m_rate = ~m_rate;
                    m_pos  = 0;
                end else m_pos++;
            end else begin
                if (m_in_show || m_hold != int'(mode)) begin
                    m_in_show = 1'b0;
                    m_hold    = int'(mode);
                    m_hpos    = 0;
                end
                case (mode)
                    2'b01: begin
                        m_light = bounce_q[m_hpos];
                        m_hpos  = (m_hpos + 1) % bounce_q.size();
                    end
                    2'b10: begin
                        m_light = alt_q[m_hpos];
                        m_hpos  = (m_hpos + 1) % alt_q.size();
                    end
                    default: m_light = 8'hFF;
                endcase
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("light", light, m_light);
        check("step", 8'(step), 8'(m_step));
        check("seq_done", 8'(seq_done), 8'(m_done));
        check("fast", 8'(fast), 8'(m_rate | fast_force));
    endtask

    task automatic do_cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic check_guard(input string tag, input int guard, input int limit);
        total++;
        assert (guard < limit) else begin
            bad++;
            $error("FAIL %s timeout observed=%0d required<%0d", tag, guard, limit);
        end
    endtask

    task automatic wait_mid_walk(input string tag);
        int guard;
        guard = 0;
        while (!(m_in_show && m_pos >= 4 && m_pos <= 8) && guard < 500) begin
            do_cycle();
            guard++;
        end
        check_guard(tag, guard, 500);
    endtask

    logic [7:0] exp_show [22] = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                  8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
                                  8'h01, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h00};
    logic [7:0] rec[$];

    initial begin
        int guard;

        show_q.push_back(8'hFF);
        show_q.push_back(8'h00);
        for (int k = 0; k < N; k++) show_q.push_back(8'(1 << k));
        for (int k = N - 2; k >= 0; k--) show_q.push_back(8'(1 << k));
        for (int k = 0; k < 2 * REPS; k++) show_q.push_back((k % 2 == 0) ? 8'h55 : 8'hAA);
        show_q.push_back(8'h00);
        for (int k = 0; k < N; k++) bounce_q.push_back(8'(1 << k));
        for (int k = N - 2; k >= 1; k--) bounce_q.push_back(8'(1 << k));
        alt_q.push_back(8'h55);
        alt_q.push_back(8'hAA);
        model_reset();

        // Reset values, then the first full slow show.
        run(3);
        rst = 1'b0;
        en  = 1'b1;
        guard = 0;
        while (guard < 300) begin
            do_cycle();
            guard++;
            if (step) rec.push_back(light);
            if (seq_done) break;
        end
        check_guard("first_show", guard, 300);
        check("show_len", 8'(rec.size()), 8'd22);
        for (int i = 0; i < 22 && i < rec.size(); i++) check("show_pattern", rec[i], exp_show[i]);
        check("fast_after_show", 8'(fast), 8'd1);
        run(30);

        // Pause mid-walk.
        wait_mid_walk("wait_walk_pause");
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(20);

        // Hold bounce entered during the alternating phase, then other holds.
        guard = 0;
        while (!(m_in_show && m_pos == 18) && guard < 500) begin
            do_cycle();
            guard++;
        end
        check_guard("wait_alt", guard, 500);
        mode = 2'b01;
        run(60);
        mode = 2'b10;
        run(16);
        mode = 2'b11;
        run(10);
        mode = 2'b01;
        run(12);
        mode = 2'b00;
        run(30);

        // Forced fast mid-count.
        run(1);
        fast_force = 1'b1;
        run(12);
        fast_force = 1'b0;
        run(12);

        // Randomised operation.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 2) fast_force = ~fast_force;
            do_cycle();
        end

        // Asynchronous reset mid-walk.
        mode       = 2'b00;
        fast_force = 1'b0;
        en         = 1'b1;
        wait_mid_walk("wait_walk_reset");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        check("async_rst_light", light, 8'h00);
        run(2);
        rst = 1'b0;
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lig_seq.md
Name: lig_seq

Overview:
- Parametrised LED pattern sequencer; successor to the fixed 8-LED light-show block on the board top level.
- Drives N LEDs through a fixed show: all-on, all-off, walk up, walk back (bounce), alternating toggle repeated, end.
- Adds async reset, run/pause, hold modes, a forced-fast input, and status pulses.
- Step rate alternates slow/fast after each completed show.

Parameters:
N, 8, LED count; legal range N >= 2.
SLOW_DIV, 50000, clk100khz cycles per step at slow rate; must be >= 2.
FAST_DIV, 5000, clk100khz cycles per step at fast rate; must be >= 2.
ALT_REPS, 2, number of alternating-pattern pairs per show; must be >= 1.

Ports:
clk100khz  in   1  system clock, rising edge.
rst        in   1  asynchronous active-high reset.
en         in   1  1 = run; 0 = freeze divider, state and outputs.
mode       in   2  00 auto show; 01 hold bounce; 10 hold alternate; 11 hold all-on.
fast_force in   1  1 = use FAST_DIV regardless of show rate.
light      out  N  LED drive, bit 0 = first LED.
step       out  1  one-cycle pulse on every pattern update (tick).
seq_done   out  1  one-cycle pulse when an auto show completes.
fast       out  1  effective rate in use (1 = FAST_DIV).

Behaviour:
- Reset (async, rst=1): light=0, step=0, seq_done=0, rate_fast=0, fast=0, divider=0, state=S_ON, ALT counter=0.
- Divider: DIV = fast ? FAST_DIV : SLOW_DIV, with fast = rate_fast | fast_force.
  - Counts 0..DIV-1 while en=1.
  - tick = en & (count == DIV-1); count wraps to 0 on tick.
  - If fast changes value, count clears to 0 in that cycle and no tick is issued.
  - Counter width = $clog2(max(SLOW_DIV, FAST_DIV)).
- step equals tick, registered so it coincides with the light update.
- All state and light changes occur only on tick. en=0 holds everything; outputs stay static.
- Auto show (mode=00); on each tick:
  - S_ON: light=all ones; next S_OFF.
  - S_OFF: light=0; next S_WALK_U.
  - S_WALK_U: light = 1<<k for k=0..N-1 on successive ticks. The tick loading bit N-1 moves to S_WALK_D.
  - S_WALK_D: light = 1<<k for k=N-2 down to 0. The tick loading bit 0 moves to S_ALT.
  - S_ALT: first tick loads the pattern with bit0=1 and alternating bits (N=8: 0x55); each later tick inverts light. Total 2*ALT_REPS ticks, then S_END.
  - S_END: light=0, seq_done=1 for one cycle, rate_fast toggles; next S_ON.
- Show length = 3 + N + (N-1) + 2*ALT_REPS ticks (N=8, ALT_REPS=2: 22).
- Hold modes; mode is sampled only on tick:
  - mode!=00 on a tick: enter the hold state and load its first pattern on that same tick.
  - 01: bounce 1<<0..1<<N-1..1<<0 continuously; the end bits are not repeated.
  - 10: alternate pattern (0x55 then 0xAA for N=8) forever.
  - 11: all ones.
  - Holds never assert seq_done and never toggle rate_fast.
- Return from hold to 00: the tick sees 00 and restarts the show at S_ON, loading all ones on that tick.
- Mode change between holds restarts the new hold pattern from its first value.
- rst mid-show: immediate return to reset values; the show restarts at slow rate.

Decomposition:
- Package lig_pkg: state enum (S_ON, S_OFF, S_WALK_U, S_WALK_D, S_ALT, S_END, S_HOLD_BOUNCE, S_HOLD_ALT, S_HOLD_ON) and mode constants (MODE_AUTO, MODE_BOUNCE, MODE_ALT, MODE_ON).
- One sub-module, lig_tick_gen: owns the divider and the fast-switch clear; outputs tick.

Test Plan (N=8, SLOW_DIV=4, FAST_DIV=2, ALT_REPS=2):
- Reset, en=1, mode=00: light sequence is FF,00,01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,55,AA,55,AA,00 at one tick per 4 cycles. seq_done pulses with the final 00; fast goes to 1; the next show steps every 2 cycles.
- en=0 mid-walk for 10 cycles: light, state and count stay frozen. Resume with en=1 gives the next tick exactly after the remaining count.
- mode=01 on a tick during S_ALT: light=01, then bounces 02..80..01 indefinitely; seq_done never asserts; fast unchanged.
- mode 10 then back to 00: light alternates 55/AA; the first tick after returning to 00 loads FF.
- fast_force toggled 0->1 mid-count: count clears, fast=1, first tick arrives 2 cycles later, no spurious step.
- rst asserted asynchronously mid-S_WALK_U (between clock edges): light=00, fast=0, seq_done=0 immediately. After release, the first tick loads FF.
